rx_packet_framer: RTL and testbench

Receive-path packet assembler between the per-channel RX FIFOs (data channels 0..NUM_CHAN-1 plus the command-response FIFO at index NUM_CHAN) and the 4k×16 USB-side FIFO. It round-robins over channels that hold enough data. For each selected channel it emits one fixed 256-word inband packet: 4 header words (flags, length, RSSI, channel, timestamp), then payload, then zero padding. Runs entirely in the rxclk domain.

---
 rtl/rx_packet_framer.sv | 226 ++++++++++++++++++++++
 tb/tb_rx_packet_framer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_framer.sv
// rx_packet_framer
//   Receive-path packet assembler. Round-robins over the data channels and
//   the command-response channel (index NUM_CHAN). For each winner it writes
//   one fixed 256-word inband packet to the USB-side FIFO: 4 header words,
//   then len payload words, then zero padding.
//
// Ports
//   rxclk, reset      clock (rising edge), asynchronous active-low reset
//   adctime           sample-time counter, latched as the packet timestamp
//   chan_empty        per-channel "cannot supply a packet" flags
//   chan_usedw        word count of the FIFO addressed by rd_select
//   chan_fifodata     q of the addressed FIFO, valid one cycle after chan_rdreq
//   rd_select         FIFO mux select, held for the whole packet
//   chan_rdreq        read strobe to the selected FIFO
//   have_space        USB FIFO can take a full packet (checked only in IDLE)
//   WR, fifodata      USB FIFO write strobe / data (data is zero when WR=0)
//   rssi_0..rssi_3    per-channel signal strength
//   underrun          TX underrun pulses for channels 0/1
//   debugbus          {state, rd_select}
//
// state   | meaning
// IDLE    | wait for space and a ready channel, pick the next one
// SELECT  | rd_select valid; latch timestamp and payload length
// HDR0    | write flags/length word
// HDR1    | write rssi/channel word
// TS_LO   | write timestamp[15:0]
// TS_HI   | write timestamp[31:16]; first payload read issued
// PAYLOAD | forward len FIFO words
// PAD     | write zeros up to 252 data words
module rx_packet_framer #(
  parameter int NUM_CHAN = 2
) (
  input  logic                rxclk,
  input  logic                reset,
  input  logic [31:0]         adctime,
  input  logic [NUM_CHAN:0]   chan_empty,
  input  logic [9:0]          chan_usedw,
  input  logic [15:0]         chan_fifodata,
  output logic [3:0]          rd_select,
  output logic                chan_rdreq,
  input  logic                have_space,
  output logic                WR,
  output logic [15:0]         fifodata,
  input  logic [31:0]         rssi_0,
  input  logic [31:0]         rssi_1,
  input  logic [31:0]         rssi_2,
  input  logic [31:0]         rssi_3,
  input  logic [1:0]          underrun,
  output logic [7:0]          debugbus
);

  localparam logic [3:0] CMD_CHAN = 4'(NUM_CHAN);
  localparam logic [7:0] MAX_LEN  = 8'd252;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    SELECT  = 4'd1,
    HDR0    = 4'd2,
    HDR1    = 4'd3,
    TS_LO   = 4'd4,
    TS_HI   = 4'd5,
    PAYLOAD = 4'd6,
    PAD     = 4'd7
  } state_t;

  state_t      state;
  logic [3:0]  last_served;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic [31:0] ts_q;
  logic [15:0] word_q;
  logic [1:0]  urun_q;

  // Round-robin search starting one past the last served channel.
  // Padding with ones keeps the 4-bit index inside the vector.
  logic [15:0] empty_ext;
  logic [3:0]  pick;
  logic [3:0]  idx;
  logic        found;

  assign empty_ext = {{(15 - NUM_CHAN){1'b1}}, chan_empty};

  always_comb begin
    pick  = 4'd0;
    found = 1'b0;
    idx   = 4'd0;
    for (int i = 1; i <= NUM_CHAN + 1; i++) begin
      idx = last_served + 4'(i);
      if (idx > CMD_CHAN) idx = idx - (CMD_CHAN + 4'd1);
      if (!found && !empty_ext[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Header fields, all derived from the held rd_select.
  logic        is_cmd;
  logic [7:0]  len_sel;
  logic [31:0] rssi_sel;
  logic [5:0]  rssi_sat;
  logic [4:0]  chan_field;
  logic        urun_rpt;
  logic [15:0] word0;
  logic [15:0] word1;

  assign is_cmd  = (rd_select == CMD_CHAN);
  assign len_sel = !is_cmd                       ? MAX_LEN :
                   (chan_usedw > 10'(MAX_LEN))   ? MAX_LEN : chan_usedw[7:0];

  always_comb begin
    rssi_sel = rssi_0;
    if (!is_cmd) begin
      case (rd_select)
        4'd1:    rssi_sel = rssi_1;
        4'd2:    rssi_sel = rssi_2;
        4'd3:    rssi_sel = rssi_3;
        default: rssi_sel = rssi_0;
      endcase
    end
  end

  assign rssi_sat   = (rssi_sel > 32'd63) ? 6'd63 : rssi_sel[5:0];
  assign chan_field = is_cmd ? 5'd31 : {1'b0, rd_select};

  // A pulse arriving while word0 is being built is reported right away,
  // so it is not lost when the sticky bit is cleared in HDR0.
  assign urun_rpt = (!is_cmd && rd_select < 4'd2) ?
                    (urun_q[rd_select[0]] | underrun[rd_select[0]]) : 1'b0;

  assign word0 = {1'b0, urun_rpt, 2'b11, 3'b000, len_sel, 1'b0};
  assign word1 = {rssi_sat, chan_field, 5'd0};

  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rd_select   <= 4'd0;
      last_served <= CMD_CHAN;
      chan_rdreq  <= 1'b0;
      WR          <= 1'b0;
      word_q      <= 16'h0000;
      len_q       <= 8'd0;
      cnt_q       <= 8'd0;
      ts_q        <= 32'd0;
      urun_q      <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (underrun[i])
          urun_q[i] <= 1'b1;
        else if (state == HDR0 && rd_select == 4'(i))
          urun_q[i] <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (have_space && found) begin
            rd_select <= pick;
            state     <= SELECT;
          end
        end
        SELECT: begin
          len_q  <= len_sel;
          ts_q   <= adctime;
          word_q <= word0;
          WR     <= 1'b1;
          state  <= HDR0;
        end
        HDR0: begin
          word_q <= word1;
          state  <= HDR1;
        end
        HDR1: begin
          word_q <= ts_q[15:0];
          state  <= TS_LO;
        end
        TS_LO: begin
          word_q     <= ts_q[31:16];
          chan_rdreq <= (len_q != 8'd0);
          state      <= TS_HI;
        end
        TS_HI: begin
          // read issued here lands on the first PAYLOAD cycle
          word_q     <= 16'h0000;
          chan_rdreq <= (len_q > 8'd1);
          if (len_q == 8'd0) begin
            cnt_q <= MAX_LEN;
            state <= PAD;
          end else begin
            cnt_q <= len_q;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          // cnt_q = payload words still to write, including this one
          cnt_q      <= cnt_q - 8'd1;
          chan_rdreq <= (cnt_q > 8'd2);
          if (cnt_q == 8'd1) begin
            if (len_q == MAX_LEN) begin
              WR          <= 1'b0;
              last_served <= rd_select;
              state       <= IDLE;
            end else begin
              cnt_q <= MAX_LEN - len_q;
              state <= PAD;
            end
          end
        end
        PAD: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            WR          <= 1'b0;
            last_served <= rd_select;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload words come straight from the FIFO q, which is valid the cycle
  // after each read; everything else comes from the word register.
  assign fifodata = (state == PAYLOAD) ? chan_fifodata : word_q;
  assign debugbus = {state, rd_select};

endmodule

// File: tb/tb_rx_packet_framer.sv
// Directed bench for rx_packet_framer: a FIFO model answers reads on the
// selected channel, every packet is captured word by word and compared
// against hand-derived header, payload and padding values.
module tb_rx_packet_framer;

  localparam int          NC      = 2;
  localparam logic [31:0] TS_BASE = 32'h1234_0000;

  logic        rxclk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] adctime;
  logic [NC:0] chan_empty;
  logic [9:0]  chan_usedw;
  logic [15:0] chan_fifodata;
  logic [3:0]  rd_select;
  logic        chan_rdreq;
  logic        have_space;
  logic        WR;
  logic [15:0] fifodata;
  logic [31:0] rssi_0, rssi_1, rssi_2, rssi_3;
  logic [1:0]  underrun;
  logic [7:0]  debugbus;

  rx_packet_framer #(.NUM_CHAN(NC)) dut (
    .rxclk         (rxclk),
    .reset         (reset),
    .adctime       (adctime),
    .chan_empty    (chan_empty),
    .chan_usedw    (chan_usedw),
    .chan_fifodata (chan_fifodata),
    .rd_select     (rd_select),
    .chan_rdreq    (chan_rdreq),
    .have_space    (have_space),
    .WR            (WR),
    .fifodata      (fifodata),
    .rssi_0        (rssi_0),
    .rssi_1        (rssi_1),
    .rssi_2        (rssi_2),
    .rssi_3        (rssi_3),
    .underrun      (underrun),
    .debugbus      (debugbus)
  );

  always #5 rxclk = ~rxclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int cmd_total = 0;
  int last_c0  = 0;
  int pk       = 0;
  int ptr     [0:2];
  int exp_ptr [0:2];
  logic       rq_s  = 1'b0;
  logic       wr_s  = 1'b0;
  logic [3:0] sel_s = 4'd0;

  // Stimulus data pattern for each source FIFO.
  function automatic logic [15:0] fifo_word(input int ch, input int p);
    case (ch)
      0:       return 16'(p + 1);
      1:       return 16'(32'h1000 + p);
      default: return 16'(32'hA0 + p);
    endcase
  endfunction

  // FIFO model: a read sampled in cycle n presents its word in cycle n+1.
  always @(negedge rxclk) begin
    rq_s  = chan_rdreq;
    wr_s  = WR;
    sel_s = rd_select;
  end

  always @(posedge rxclk) begin
    #1;
    cyc     = cyc + 1;
    adctime = TS_BASE + 32'(cyc);
    if (wr_s) wr_cnt = wr_cnt + 1;
    if (rq_s && reset) begin
      rd_cnt = rd_cnt + 1;
      if (sel_s <= 4'd2) begin
        chan_fifodata = fifo_word(int'(sel_s), ptr[sel_s]);
        ptr[sel_s]    = ptr[sel_s] + 1;
      end
    end
  end

  assign chan_usedw = (rd_select == 4'd2) ? 10'(cmd_total - ptr[2]) : 10'd600;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for the next packet and check all 256 words of it.
  task automatic pkt(input int ch, input int len, input bit urun, input int rssi_f,
                     input int gap, input bit stop);
    logic [15:0] w [0:255];
    logic [31:0] ts;
    int t, c0, r0, bad_pay, bad_pad, bad_wr, bad_sel;
    t = 0; bad_pay = 0; bad_pad = 0; bad_wr = 0; bad_sel = 0;
    pk++;
    r0 = rd_cnt;
    @(negedge rxclk);
    while (WR !== 1'b1 && t < 700) begin
      @(negedge rxclk);
      t++;
    end
    chk($sformatf("p%0d_start_timeout", pk), 32'(t < 700), 32'd1);
    if (t >= 700) return;
    if (stop) chan_empty = '1;
    c0 = cyc;
    chk($sformatf("p%0d_debugbus", pk), 32'(debugbus), 32'({4'd2, 4'(ch)}));
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge rxclk);
      w[i] = fifodata;
      if (WR !== 1'b1) bad_wr++;
      if (rd_select !== 4'(ch)) bad_sel++;
    end
    @(negedge rxclk);
    chk($sformatf("p%0d_wr_after_last", pk), 32'(WR), 32'd0);
    ts = TS_BASE + 32'(c0 - 1);
    chk($sformatf("p%0d_hdr0", pk), 32'(w[0]), 32'({1'b0, urun, 2'b11, 3'b000, 9'(len * 2)}));
    chk($sformatf("p%0d_hdr1", pk), 32'(w[1]),
        32'({6'(rssi_f), (ch == NC) ? 5'd31 : 5'(ch), 5'd0}));
    chk($sformatf("p%0d_ts_lo", pk), 32'(w[2]), 32'(ts[15:0]));
    chk($sformatf("p%0d_ts_hi", pk), 32'(w[3]), 32'(ts[31:16]));
    for (int j = 0; j < len; j++)
      if (w[4 + j] !== fifo_word(ch, exp_ptr[ch] + j)) bad_pay++;
    for (int j = len; j < 252; j++)
      if (w[4 + j] !== 16'h0000) bad_pad++;
    chk($sformatf("p%0d_payload_bad_words", pk), 32'(bad_pay), 32'd0);
    chk($sformatf("p%0d_pad_bad_words", pk), 32'(bad_pad), 32'd0);
    chk($sformatf("p%0d_wr_gaps", pk), 32'(bad_wr), 32'd0);
    chk($sformatf("p%0d_rd_select_changes", pk), 32'(bad_sel), 32'd0);
    chk($sformatf("p%0d_rdreq_count", pk), 32'(rd_cnt - r0), 32'(len));
    if (gap > 0) chk($sformatf("p%0d_spacing", pk), 32'(c0 - last_c0), 32'(gap));
    last_c0 = c0;
    exp_ptr[ch] += len;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, w0, r0;
    chan_empty    = '1;
    have_space    = 1'b1;
    underrun      = 2'b00;
    rssi_0        = 32'd20;
    rssi_1        = 32'd200;
    rssi_2        = 32'd5;
    rssi_3        = 32'd7;
    chan_fifodata = 16'h0000;
    adctime       = TS_BASE;
    for (int i = 0; i < 3; i++) begin
      ptr[i]     = 0;
      exp_ptr[i] = 0;
    end

    // reset state
    reset = 1'b0;
    repeat (3) @(negedge rxclk);
    chk("rst_wr", 32'(WR), 32'd0);
    chk("rst_rdreq", 32'(chan_rdreq), 32'd0);
    chk("rst_rd_select", 32'(rd_select), 32'd0);
    chk("rst_fifodata", 32'(fifodata), 32'd0);
    chk("rst_debugbus", 32'(debugbus), 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge rxclk);
    chk("idle_nothing_ready_wr", 32'(wr_cnt), 32'd0);

    // channel 0 ramp packet
    chan_empty = 3'b110;
    pkt(0, 252, 1'b0, 20, 0, 1'b1);

    // short command-channel packet with padding
    cmd_total  = 10;
    chan_empty = 3'b011;
    pkt(2, 10, 1'b0, 20, 0, 1'b1);

    // everyone ready: round-robin order and back-to-back spacing
    cmd_total  = 310;
    chan_empty = 3'b000;
    pkt(0, 252, 1'b0, 20, 0, 1'b0);
    pkt(1, 252, 1'b0, 63, 258, 1'b0);
    pkt(2, 252, 1'b0, 20, 258, 1'b0);
    pkt(0, 252, 1'b0, 20, 258, 1'b1);

    // no space: nothing starts; losing space mid-packet does not stall it
    have_space = 1'b0;
    chan_empty = 3'b101;
    w0 = wr_cnt;
    r0 = rd_cnt;
    repeat (300) @(negedge rxclk);
    chk("nospace_wr", 32'(wr_cnt - w0), 32'd0);
    chk("nospace_rdreq", 32'(rd_cnt - r0), 32'd0);
    have_space = 1'b1;
    fork
      begin
        repeat (40) @(negedge rxclk);
        have_space = 1'b0;
      end
    join_none
    pkt(1, 252, 1'b0, 63, 0, 1'b1);
    have_space = 1'b1;

    // underrun on channel 1 while channel 0 is in flight
    chan_empty = 3'b110;
    fork
      begin
        repeat (100) @(negedge rxclk);
        underrun = 2'b10;
        @(negedge rxclk);
        underrun = 2'b00;
        repeat (20) @(negedge rxclk);
        chan_empty = 3'b101;
      end
    join_none
    pkt(0, 252, 1'b0, 20, 0, 1'b0);
    pkt(1, 252, 1'b1, 63, 258, 1'b0);
    pkt(1, 252, 1'b0, 63, 258, 1'b1);

    // reset at payload word 100 of a channel 1 packet
    chan_empty = 3'b101;
    t = 0;
    @(negedge rxclk);
    while (WR !== 1'b1 && t < 700) begin
      @(negedge rxclk);
      t++;
    end
    chk("abort_start_timeout", 32'(t < 700), 32'd1);
    repeat (50) @(negedge rxclk);
    underrun = 2'b01;
    @(negedge rxclk);
    underrun = 2'b00;
    repeat (52) @(negedge rxclk);
    chk("abort_pre_wr", 32'(WR), 32'd1);
    chk("abort_pre_rdreq", 32'(chan_rdreq), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_wr", 32'(WR), 32'd0);
    chk("abort_rdreq", 32'(chan_rdreq), 32'd0);
    chk("abort_fifodata", 32'(fifodata), 32'd0);
    chk("abort_rd_select", 32'(rd_select), 32'd0);
    chk("abort_debugbus", 32'(debugbus), 32'd0);
    exp_ptr[1] += 100;
    @(negedge rxclk);
    chk("abort_hold_wr", 32'(WR), 32'd0);
    reset      = 1'b1;
    chan_empty = 3'b000;
    pkt(0, 252, 1'b0, 20, 0, 1'b1);

    repeat (5) @(negedge rxclk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
